// File: rtl/pmem_ram_ldr.sv
// Parametrised instruction memory: 1- or 2-cycle fetch pipeline with stall,
// fetch error flags, and a little-endian byte-stream boot loader.
module pmem_ram_ldr #(
    parameter int          DEPTH     = 256,
    parameter int          ADDR_W    = 10,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_read_c0,
    input  logic              rd_en_c0,
    input  logic              stall,
    output logic [31:0]       instr_reg_c1,
    output logic              instr_vld,
    output logic [1:0]        fetch_err,
    input  logic              ld_start,
    input  logic [7:0]        ld_byte,
    input  logic              ld_byte_vld,
    input  logic              ld_last,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_ovf
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} ld_state_t;

    logic [31:0]      mem [DEPTH];

    ld_state_t        state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [1:0]       cnt_reg, cnt_next;
    logic [31:0]      asm_reg, asm_next;
    logic             full_reg, full_next;
    logic             ovf_reg, ovf_next;
    logic             mem_we;
    logic [31:0]      mem_wdata;

    logic [IDX_W-1:0] f_idx;
    logic             f_mis, f_oor, f_accept, f_rd_ok;
    logic [31:0]      rd_data_reg;
    logic             s1_vld_reg, s1_nop_reg;
    logic [1:0]       s1_err_reg;
    logic [31:0]      s1_instr;

    assign ld_busy = (state_reg != ST_IDLE);
    assign ld_done = (state_reg == ST_DONE);
    assign ld_ovf  = ovf_reg;

    // ---------------- loader ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            asm_reg   <= '0;
            full_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            asm_reg   <= asm_next;
            full_reg  <= full_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        asm_next   = asm_reg;
        full_next  = full_reg;
        ovf_next   = ovf_reg;
        mem_we     = 1'b0;
        // Unfilled upper bytes of asm_reg are zero, which gives the zero-fill on ld_last.
        mem_wdata  = asm_reg | (32'(ld_byte) << {cnt_reg, 3'b000});
        case (state_reg)
            ST_IDLE: begin
                if (ld_start) begin
                    state_next = ST_LOAD;
                    ptr_next   = '0;
                    cnt_next   = '0;
                    asm_next   = '0;
                    full_next  = 1'b0;
                    ovf_next   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (ld_start) begin
                    ptr_next  = '0;
                    cnt_next  = '0;
                    asm_next  = '0;
                    full_next = 1'b0;
                    ovf_next  = 1'b0;
                end else if (ld_byte_vld) begin
                    if (full_reg) begin
                        ovf_next = 1'b1;
                    end else if (cnt_reg == 2'd3 || ld_last) begin
                        mem_we   = 1'b1;
                        cnt_next = '0;
                        asm_next = '0;
                        if (ptr_reg == LAST_IDX) full_next = 1'b1;
                        else                     ptr_next  = ptr_reg + 1'b1;
                    end else begin
                        asm_next = mem_wdata;
                        cnt_next = cnt_reg + 1'b1;
                    end
                    if (ld_last) state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_reg] <= mem_wdata;
    end

    // ---------------- fetch ----------------
    assign f_idx    = pc_read_c0[IDX_W+1:2];
    assign f_mis    = |pc_read_c0[1:0];
    assign f_accept = rd_en_c0 & ~stall;
    assign f_rd_ok  = f_accept & ~ld_busy & ~f_mis & ~f_oor;

    generate
        if (ADDR_W > IDX_W + 2) begin : g_oor
            assign f_oor = |pc_read_c0[ADDR_W-1:IDX_W+2];
        end else begin : g_no_oor
            assign f_oor = 1'b0;
        end
    endgenerate

    // Read port only fires for good fetches; a loader write is never concurrent.
    always_ff @(posedge clk) begin
        if (f_rd_ok) rd_data_reg <= mem[f_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_reg <= 1'b0;
            s1_err_reg <= 2'b00;
            s1_nop_reg <= 1'b1;
        end else if (!stall) begin
            s1_vld_reg <= rd_en_c0;
            if (f_accept) begin
                s1_err_reg <= ld_busy ? 2'b00 : {f_oor, f_mis};
                s1_nop_reg <= ld_busy | f_mis | f_oor;
            end else begin
                s1_err_reg <= 2'b00;
            end
        end
    end

    assign s1_instr = s1_nop_reg ? NOP_INSTR : rd_data_reg;

    generate
        if (LATENCY == 1) begin : g_lat1
            assign instr_reg_c1 = s1_instr;
            assign instr_vld    = s1_vld_reg;
            assign fetch_err    = s1_err_reg;
        end else if (LATENCY == 2) begin : g_lat2
            logic [31:0] s2_instr_reg;
            logic        s2_vld_reg;
            logic [1:0]  s2_err_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_instr_reg <= NOP_INSTR;
                    s2_vld_reg   <= 1'b0;
                    s2_err_reg   <= 2'b00;
                end else if (!stall) begin
                    s2_instr_reg <= s1_instr;
                    s2_vld_reg   <= s1_vld_reg;
                    s2_err_reg   <= s1_err_reg;
                end
            end
            assign instr_reg_c1 = s2_instr_reg;
            assign instr_vld    = s2_vld_reg;
            assign fetch_err    = s2_err_reg;
        end else begin : g_bad_latency
            $error("pmem_ram_ldr: LATENCY must be 1 or 2");
        end
    endgenerate
endmodule

// File: tb/tb_pmem_ram_ldr.sv
// Bench for pmem_ram_ldr: two instances (256 words/1-cycle, 16 words/2-cycle)
// driven from shared stimulus; vector table plus load/overflow/reset sequences.
module tb_pmem_ram_ldr;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] W0  = 32'h00000113;
    localparam logic [31:0] W1  = 32'h000047B7;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pc;
    logic        rd_en, stall, ld_start, ld_byte_vld, ld_last;
    logic [7:0]  ld_byte;

    logic [31:0] instr_a, instr_b;
    logic        vld_a, vld_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
    logic [1:0]  err_a, err_b;

    int checks = 0;
    int errors = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always #5 clk = ~clk;

    pmem_ram_ldr #(.DEPTH(256), .ADDR_W(10), .LATENCY(1), .NOP_INSTR(NOP)) dut_a (
        .clk(clk), .rst(rst), .pc_read_c0(pc[9:0]), .rd_en_c0(rd_en), .stall(stall),
        .instr_reg_c1(instr_a), .instr_vld(vld_a), .fetch_err(err_a),
        .ld_start(ld_start), .ld_byte(ld_byte), .ld_byte_vld(ld_byte_vld), .ld_last(ld_last),
        .ld_busy(busy_a), .ld_done(done_a), .ld_ovf(ovf_a)
    );

    pmem_ram_ldr #(.DEPTH(16), .ADDR_W(12), .LATENCY(2), .NOP_INSTR(NOP)) dut_b (
        .clk(clk), .rst(rst), .pc_read_c0(pc), .rd_en_c0(rd_en), .stall(stall),
        .instr_reg_c1(instr_b), .instr_vld(vld_b), .fetch_err(err_b),
        .ld_start(ld_start), .ld_byte(ld_byte), .ld_byte_vld(ld_byte_vld), .ld_last(ld_last),
        .ld_busy(busy_b), .ld_done(done_b), .ld_ovf(ovf_b)
    );

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
    end

    typedef struct packed {
        logic        st, bv, last;
        logic [7:0]  b;
        logic        re, stl;
        logic [11:0] pc;
        logic        av;
        logic [31:0] ai;
        logic [1:0]  ae;
        logic        bvd;
        logic [31:0] bi;
        logic [1:0]  be;
        logic        busy, done;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_byte = b; ld_byte_vld = 1'b1; ld_last = last;
        tick();
        ld_byte_vld = 1'b0; ld_last = 1'b0;
    endtask

    // One-cycle fetch: dut_a result after one edge, dut_b after two.
    task automatic fetch1(input logic [11:0] p, input logic [31:0] ea, input logic [1:0] eea,
                          input logic [31:0] eb, input logic [1:0] eeb);
        pc = p; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk($sformatf("fetch a vld pc=%h", p), 32'(vld_a), 32'd1);
        chk($sformatf("fetch a instr pc=%h", p), instr_a, ea);
        chk($sformatf("fetch a err pc=%h", p), 32'(err_a), 32'(eea));
        tick();
        chk($sformatf("fetch b vld pc=%h", p), 32'(vld_b), 32'd1);
        chk($sformatf("fetch b instr pc=%h", p), instr_b, eb);
        chk($sformatf("fetch b err pc=%h", p), 32'(err_b), 32'(eeb));
        $display("fetch pc=%h a=%h/%b b=%h/%b", p, instr_a, err_a, instr_b, err_b);
    endtask

    initial begin
        int base_a, base_b;
        //          st  bv  last b      re  stl pc       av  ai   ae     bvd bi   be     busy done
        vecs[0]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,12'h000,1'b0,NOP,2'b00,1'b0,NOP,2'b00,1'b1,1'b0};
        vecs[1]  = '{1'b0,1'b1,1'b0,8'h13,1'b1,1'b0,12'h000,1'b1,NOP,2'b00,1'b0,NOP,2'b00,1'b1,1'b0};
        vecs[2]  = '{1'b0,1'b1,1'b0,8'h01,1'b1,1'b0,12'h000,1'b1,NOP,2'b00,1'b1,NOP,2'b00,1'b1,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b0,12'h000,1'b1,NOP,2'b00,1'b1,NOP,2'b00,1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,8'h00,1'b1,1'b0,12'h000,1'b1,NOP,2'b00,1'b1,NOP,2'b00,1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,8'hB7,1'b1,1'b0,12'h000,1'b1,NOP,2'b00,1'b1,NOP,2'b00,1'b1,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b1,8'h47,1'b1,1'b0,12'h000,1'b1,NOP,2'b00,1'b1,NOP,2'b00,1'b1,1'b1};
        vecs[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h000,1'b1,NOP,2'b00,1'b1,NOP,2'b00,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h000,1'b1,W0 ,2'b00,1'b1,NOP,2'b00,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h004,1'b1,W1 ,2'b00,1'b1,W0 ,2'b00,1'b0,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,12'h000,1'b0,NOP,2'b00,1'b1,W1 ,2'b00,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h006,1'b1,NOP,2'b01,1'b0,NOP,2'b00,1'b0,1'b0};
        vecs[12] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h400,1'b1,W0 ,2'b00,1'b1,NOP,2'b01,1'b0,1'b0};
        vecs[13] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h004,1'b1,W1 ,2'b00,1'b1,NOP,2'b10,1'b0,1'b0};
        vecs[14] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,12'h000,1'b0,NOP,2'b00,1'b1,W1 ,2'b00,1'b0,1'b0};
        vecs[15] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,12'h000,1'b0,NOP,2'b00,1'b0,NOP,2'b00,1'b0,1'b0};
        vecs[16] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h000,1'b1,W0 ,2'b00,1'b0,NOP,2'b00,1'b0,1'b0};
        vecs[17] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h004,1'b1,W1 ,2'b00,1'b1,W0 ,2'b00,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,12'h000,1'b1,W1 ,2'b00,1'b1,W0 ,2'b00,1'b0,1'b0};
        vecs[19] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,12'h000,1'b1,W1 ,2'b00,1'b1,W0 ,2'b00,1'b0,1'b0};
        vecs[20] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,12'h000,1'b1,W1 ,2'b00,1'b1,W0 ,2'b00,1'b0,1'b0};
        vecs[21] = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,12'h000,1'b1,W0 ,2'b00,1'b1,W1 ,2'b00,1'b0,1'b0};
        vecs[22] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,12'h000,1'b0,NOP,2'b00,1'b1,W0 ,2'b00,1'b0,1'b0};
        vecs[23] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,12'h000,1'b0,NOP,2'b00,1'b0,NOP,2'b00,1'b0,1'b0};

        rst = 1'b1; pc = '0; rd_en = 1'b0; stall = 1'b0;
        ld_start = 1'b0; ld_byte = '0; ld_byte_vld = 1'b0; ld_last = 1'b0;
        tick(); tick();
        chk("reset a instr", instr_a, NOP);
        chk("reset b instr", instr_b, NOP);
        chk("reset vld", {30'd0, vld_a, vld_b}, 32'd0);
        chk("reset err", {28'd0, err_a, err_b}, 32'd0);
        chk("reset ld flags", {26'd0, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b}, 32'd0);
        $display("reset: a=%h b=%h vld=%b%b", instr_a, instr_b, vld_a, vld_b);
        rst = 1'b0;

        // Table: 6-byte load with fetches during it, then fetches, errors and stall.
        for (int i = 0; i < NV; i++) begin
            ld_start = vecs[i].st; ld_byte_vld = vecs[i].bv; ld_last = vecs[i].last;
            ld_byte = vecs[i].b; rd_en = vecs[i].re; stall = vecs[i].stl; pc = vecs[i].pc;
            tick();
            chk($sformatf("v%0d a_vld", i), 32'(vld_a), 32'(vecs[i].av));
            chk($sformatf("v%0d b_vld", i), 32'(vld_b), 32'(vecs[i].bvd));
            if (vecs[i].av) begin
                chk($sformatf("v%0d a_instr", i), instr_a, vecs[i].ai);
                chk($sformatf("v%0d a_err", i), 32'(err_a), 32'(vecs[i].ae));
            end
            if (vecs[i].bvd) begin
                chk($sformatf("v%0d b_instr", i), instr_b, vecs[i].bi);
                chk($sformatf("v%0d b_err", i), 32'(err_b), 32'(vecs[i].be));
            end
            chk($sformatf("v%0d busy", i), {30'd0, busy_a, busy_b}, {30'd0, vecs[i].busy, vecs[i].busy});
            chk($sformatf("v%0d done", i), {30'd0, done_a, done_b}, {30'd0, vecs[i].done, vecs[i].done});
            $display("vec %0d: a=%h/%b/%b b=%h/%b/%b busy=%b done=%b", i,
                     instr_a, vld_a, err_a, instr_b, vld_b, err_b, busy_a, done_a);
        end
        ld_start = 1'b0; ld_byte_vld = 1'b0; ld_last = 1'b0; rd_en = 1'b0; stall = 1'b0;

        // 70-byte load: dut_b (16 words) overflows, dut_a does not.
        base_a = done_cnt_a; base_b = done_cnt_b;
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        for (int k = 0; k < 70; k++) send_byte(8'(k), k == 69);
        chk("ovf load done pulse", {30'd0, done_a, done_b}, 32'd3);
        chk("ovf load ld_ovf", {30'd0, ovf_a, ovf_b}, 32'd1);
        tick();
        chk("ovf load idle", {28'd0, busy_a, busy_b, done_a, done_b}, 32'd0);
        chk("ovf done count a", 32'(done_cnt_a - base_a), 32'd1);
        chk("ovf done count b", 32'(done_cnt_b - base_b), 32'd1);
        $display("overflow load: ovf_a=%b ovf_b=%b", ovf_a, ovf_b);
        fetch1(12'h000, 32'h03020100, 2'b00, 32'h03020100, 2'b00);
        fetch1(12'h03C, 32'h3F3E3D3C, 2'b00, 32'h3F3E3D3C, 2'b00);
        fetch1(12'h044, 32'h00004544, 2'b00, NOP, 2'b10);

        // New load clears ld_ovf; restart mid-word, then reset after 6 of 8 bytes.
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        chk("restart ovf cleared", {30'd0, ovf_a, ovf_b}, 32'd0);
        chk("restart busy", {30'd0, busy_a, busy_b}, 32'd3);
        base_a = done_cnt_a; base_b = done_cnt_b;
        send_byte(8'hEE, 1'b0);
        send_byte(8'hFF, 1'b0);
        ld_start = 1'b1; tick(); ld_start = 1'b0;
        pc = 12'h000; rd_en = 1'b1;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        chk("pre-reset a vld", 32'(vld_a), 32'd1);
        chk("pre-reset a instr", instr_a, NOP);
        #2 rst = 1'b1;
        #1;
        chk("async reset busy", {30'd0, busy_a, busy_b}, 32'd0);
        chk("async reset vld", {30'd0, vld_a, vld_b}, 32'd0);
        $display("async reset: busy=%b%b vld=%b%b", busy_a, busy_b, vld_a, vld_b);
        rd_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("reset-load no done a", 32'(done_cnt_a - base_a), 32'd0);
        chk("reset-load no done b", 32'(done_cnt_b - base_b), 32'd0);
        fetch1(12'h000, 32'hDDCCBBAA, 2'b00, 32'hDDCCBBAA, 2'b00);
        fetch1(12'h004, 32'h07060504, 2'b00, 32'h07060504, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
